rgb_sotp: RTL and testbench

Serial output stage for SK6812RGBW LED strings: a single-wire NRZ encoder.
- Pops 32-bit command words from an upstream standard (non-FWFT) FIFO.
- Converts the 24-bit RGB payload to RGBW and serialises 32 bits onto one wire using SK6812 high/low pulse timing.
- Optionally appends a string-reset/latch low period.
- Sits between the RGB command FIFO and the LED data pin.

---
 rtl/rgb_sotp_pkg.sv | 56 +++++
 rtl/rgb_sotp_rgbw_convert.sv | 24 ++
 rtl/rgb_sotp.sv | 178 +++++++++++++++++
 tb/tb_rgb_sotp.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rgb_sotp_pkg.sv
// Shared types, field positions and default timing for the SK6812RGBW serial
// output stage.
package rgb_sotp_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_BIT_HI  = 3'd3,
        ST_BIT_LO  = 3'd4,
        ST_STR_RST = 3'd5
    } state_t;

    // Control bits of a command word
    localparam int unsigned CTRL_LED_BIT     = 31;
    localparam int unsigned CTRL_STR_RST_BIT = 30;

    // Colour field slices of a command word
    localparam int unsigned RED_MSB = 23;
    localparam int unsigned RED_LSB = 16;
    localparam int unsigned GRN_MSB = 15;
    localparam int unsigned GRN_LSB = 8;
    localparam int unsigned BLU_MSB = 7;
    localparam int unsigned BLU_LSB = 0;

    // Default SK6812 timing in clocks at 96 MHz
    localparam int unsigned DEF_T0H         = 29;
    localparam int unsigned DEF_T0L         = 86;
    localparam int unsigned DEF_T1H         = 58;
    localparam int unsigned DEF_T1L         = 58;
    localparam int unsigned DEF_STR_RST     = 7680;
    localparam int unsigned DEF_COUNTER_MAX = 7800;

    // Smallest of three unsigned bytes; this is the white component
    function automatic logic [7:0] min3_u8(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [7:0] c
    );
        logic [7:0] m;
        m = a;
        if (b < m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c < m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/rgb_sotp_rgbw_convert.sv
// RGB to RGBW conversion: the common part of the three channels moves to the
// white LED, and the frame is laid out in wire order {G', R', B', W}.
module rgbw_convert
    import rgb_sotp_pkg::*;
(
    input  logic [23:0] i_rgb,
    output logic [31:0] o_frame
);

    logic [7:0] w_red;
    logic [7:0] w_grn;
    logic [7:0] w_blu;
    logic [7:0] w_wht;

    // Subtract the white level from each channel; w_wht <= every channel, so no wrap
    always_comb begin
        w_red   = i_rgb[RED_MSB:RED_LSB];
        w_grn   = i_rgb[GRN_MSB:GRN_LSB];
        w_blu   = i_rgb[BLU_MSB:BLU_LSB];
        w_wht   = min3_u8(w_red, w_grn, w_blu);
        o_frame = {w_grn - w_wht, w_red - w_wht, w_blu - w_wht, w_wht};
    end

endmodule

// File: rtl/rgb_sotp.sv
// SK6812RGBW single-wire NRZ encoder: pops command words from a standard FIFO,
// converts RGB to RGBW and shifts 32 bits MSB first with exact pulse timing,
// optionally followed by a string reset/latch low period.
module rgb_sotp
    import rgb_sotp_pkg::*;
#(
    parameter int unsigned RGBW_T0H     = DEF_T0H,
    parameter int unsigned RGBW_T0L     = DEF_T0L,
    parameter int unsigned RGBW_T1H     = DEF_T1H,
    parameter int unsigned RGBW_T1L     = DEF_T1L,
    parameter int unsigned RGBW_STR_RST = DEF_STR_RST,
    parameter int unsigned COUNTER_MAX  = DEF_COUNTER_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_rd_fifo_empty,
    input  logic [31:0] in_rd_fifo_data,
    output logic        out_rd_fifo_en,
    output logic        out_sig
);

    localparam int unsigned CNT_W = $clog2(COUNTER_MAX + 1);

    // Counters run 0..N-1, so each phase ends on its "last" value
    localparam logic [CNT_W-1:0] T0H_LAST = CNT_W'(RGBW_T0H - 1);
    localparam logic [CNT_W-1:0] T0L_LAST = CNT_W'(RGBW_T0L - 1);
    localparam logic [CNT_W-1:0] T1H_LAST = CNT_W'(RGBW_T1H - 1);
    localparam logic [CNT_W-1:0] T1L_LAST = CNT_W'(RGBW_T1L - 1);
    localparam logic [CNT_W-1:0] STR_LAST = CNT_W'(RGBW_STR_RST - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_idx;
    logic             r_sig;
    logic [31:0]      r_word;
    logic [31:0]      r_frame;
    logic             r_armed;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [4:0]       w_idx_nxt;
    logic             w_sig_nxt;
    logic [31:0]      w_word_nxt;
    logic [31:0]      w_frame_nxt;
    logic             w_rd_en;
    logic [31:0]      w_frame;
    logic             w_bit;
    logic [CNT_W-1:0] w_hi_last;
    logic [CNT_W-1:0] w_lo_last;

    rgbw_convert u_convert (
        .i_rgb   (r_word[23:0]),
        .o_frame (w_frame)
    );

    // The read strobe has to be combinational so that the FIFO sees it in the
    // same IDLE cycle the empty flag is seen low; r_armed keeps it quiet while
    // and just after reset.
    assign out_rd_fifo_en = w_rd_en;
    assign out_sig        = r_sig;

    // Next-state, counter, bit index and line-level decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_sig_nxt   = r_sig;
        w_word_nxt  = r_word;
        w_frame_nxt = r_frame;
        w_rd_en     = 1'b0;
        w_bit       = r_frame[r_idx];
        if (w_bit) begin
            w_hi_last = T1H_LAST;
            w_lo_last = T1L_LAST;
        end else begin
            w_hi_last = T0H_LAST;
            w_lo_last = T0L_LAST;
        end

        case (r_state)
            ST_IDLE: begin
                w_sig_nxt = 1'b0;
                w_cnt_nxt = '0;
                if (r_armed && !in_rd_fifo_empty) begin
                    w_rd_en     = 1'b1;
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // Non-FWFT FIFO: data is valid the cycle after the strobe
                w_word_nxt  = in_rd_fifo_data;
                w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_frame_nxt = w_frame;
                w_cnt_nxt   = '0;
                if (r_word[CTRL_LED_BIT]) begin
                    w_idx_nxt   = 5'd31;
                    w_sig_nxt   = 1'b1;
                    w_state_nxt = ST_BIT_HI;
                end else if (r_word[CTRL_STR_RST_BIT]) begin
                    w_sig_nxt   = 1'b0;
                    w_state_nxt = ST_STR_RST;
                end else begin
                    w_sig_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BIT_HI: begin
                if (r_cnt == w_hi_last) begin
                    w_cnt_nxt   = '0;
                    w_sig_nxt   = 1'b0;
                    w_state_nxt = ST_BIT_LO;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            ST_BIT_LO: begin
                if (r_cnt == w_lo_last) begin
                    w_cnt_nxt = '0;
                    if (r_idx != 5'd0) begin
                        w_idx_nxt   = r_idx - 5'd1;
                        w_sig_nxt   = 1'b1;
                        w_state_nxt = ST_BIT_HI;
                    end else if (r_word[CTRL_STR_RST_BIT]) begin
                        w_sig_nxt   = 1'b0;
                        w_state_nxt = ST_STR_RST;
                    end else begin
                        w_sig_nxt   = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_STR_RST: begin
                w_sig_nxt = 1'b0;
                if (r_cnt == STR_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_sig_nxt   = 1'b0;
                w_cnt_nxt   = '0;
                w_idx_nxt   = 5'd0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, timing and data registers; out_sig comes straight from r_sig
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= 5'd0;
            r_sig   <= 1'b0;
            r_word  <= 32'h0000_0000;
            r_frame <= 32'h0000_0000;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_sig   <= w_sig_nxt;
            r_word  <= w_word_nxt;
            r_frame <= w_frame_nxt;
            r_armed <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rgb_sotp.sv
// Self-checking bench for rgb_sotp: a queue-backed FIFO feeds the DUT and a
// per-word waveform model predicts out_sig and the read strobe every cycle.
module tb_rgb_sotp;

    localparam int T0H = 2;
    localparam int T0L = 6;
    localparam int T1H = 4;
    localparam int T1L = 4;
    localparam int STR = 20;

    logic        clk;
    logic        rst;
    logic        in_rd_fifo_empty;
    logic [31:0] in_rd_fifo_data;
    logic        out_rd_fifo_en;
    logic        out_sig;

    logic [31:0] fifo_q[$];
    bit          exp_q[$];
    int          n_cmp;
    int          n_err;
    int          n_push;
    int          n_strobe;

    rgb_sotp #(
        .RGBW_T0H     (T0H),
        .RGBW_T0L     (T0L),
        .RGBW_T1H     (T1H),
        .RGBW_T1L     (T1L),
        .RGBW_STR_RST (STR),
        .COUNTER_MAX  (7800)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_rd_fifo_empty (in_rd_fifo_empty),
        .in_rd_fifo_data  (in_rd_fifo_data),
        .out_rd_fifo_en   (out_rd_fifo_en),
        .out_sig          (out_sig)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected out_sig per cycle for one word, starting at its strobe cycle
    task automatic push_expect(input logic [31:0] w);
        int r, g, b, mn, hi, lo;
        logic [31:0] fr;
        r  = int'(w[23:16]);
        g  = int'(w[15:8]);
        b  = int'(w[7:0]);
        mn = r;
        if (g < mn) mn = g;
        if (b < mn) mn = b;
        fr = 32'(((g - mn) << 24) + ((r - mn) << 16) + ((b - mn) << 8) + mn);
        repeat (3) exp_q.push_back(1'b0);   // strobe, fetch and load cycles
        if (w[31]) begin
            for (int i = 31; i >= 0; i--) begin
                hi = fr[i] ? T1H : T0H;
                lo = fr[i] ? T1L : T0L;
                repeat (hi) exp_q.push_back(1'b1);
                repeat (lo) exp_q.push_back(1'b0);
            end
        end
        if (w[30]) begin
            repeat (STR) exp_q.push_back(1'b0);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        in_rd_fifo_empty = 1'b0;
        n_push++;
    endtask

    // One clock: check at the falling edge, update the FIFO after the rising edge
    task automatic tick();
        logic s_en;
        logic s_sig;
        @(negedge clk);
        s_en  = out_rd_fifo_en;
        s_sig = out_sig;
        if (exp_q.size() == 0) begin
            // DUT should be idle: strobe exactly when a word is waiting
            check_val("strobe_idle", 32'(s_en), 32'(fifo_q.size() != 0));
            if (s_en && fifo_q.size() != 0) begin
                push_expect(fifo_q[0]);
            end
        end else begin
            check_val("strobe_busy", 32'(s_en), 32'd0);
        end
        if (exp_q.size() != 0) begin
            check_val("sig", 32'(s_sig), 32'(exp_q.pop_front()));
        end else begin
            check_val("sig_idle", 32'(s_sig), 32'd0);
        end
        @(posedge clk);
        #1;
        if (s_en && fifo_q.size() != 0) begin
            in_rd_fifo_data = fifo_q.pop_front();
            n_strobe++;
        end else begin
            in_rd_fifo_data = $urandom;
        end
        in_rd_fifo_empty = (fifo_q.size() == 0);
    endtask

    // Run until every queued word has been fully transmitted, then idle a bit
    task automatic drain();
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 6000) begin
            tick();
            n++;
        end
        if (n >= 6000) check_val("drain_timeout", 32'd1, 32'd0);
        repeat (5) tick();
    endtask

    initial begin
        int guard;
        logic [31:0] w;
        n_cmp = 0; n_err = 0; n_push = 0; n_strobe = 0;
        rst = 1'b0;
        in_rd_fifo_empty = 1'b0;
        in_rd_fifo_data  = 32'h0000_0000;

        // Reset held with a non-empty FIFO: no strobe, line low
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_sig", 32'(out_sig), 32'd0);
        check_val("rst_en", 32'(out_rd_fifo_en), 32'd0);
        in_rd_fifo_empty = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (10) tick();

        // Directed words
        push_word(32'h8011_2233); drain();
        push_word(32'hC011_2233); drain();
        repeat (4) push_word(32'h80AA_55CC);
        drain();
        push_word(32'h0000_0000); push_word(32'h4000_0000); drain();

        // Random words arriving at random times
        for (int k = 0; k < 25; k++) begin
            w = $urandom;
            w[30] = ($urandom_range(0, 3) == 0);
            push_word(w);
            repeat ($urandom_range(1, 300)) tick();
        end
        drain();
        check_val("strobe_count", 32'(n_strobe), 32'(n_push));

        // Reset while the line is high in the middle of a bit
        for (int k = 0; k < 3; k++) begin
            w = $urandom;
            w[31] = 1'b1;
            push_word(w);
        end
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!(exp_q.size() > 40 && exp_q[0] == 1'b1) && guard < 400);
        if (guard >= 400) check_val("mid_bit_timeout", 32'd1, 32'd0);
        #2;
        check_val("pre_rst_sig", 32'(out_sig), 32'd1);
        rst = 1'b0;
        #1;
        check_val("rst_mid_sig", 32'(out_sig), 32'd0);
        check_val("rst_mid_en", 32'(out_rd_fifo_en), 32'd0);
        fifo_q.delete();
        exp_q.delete();
        in_rd_fifo_empty = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (30) tick();

        // Still alive after reset
        push_word(32'hC0FF_0080); drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
